// File: rtl/uart_tx_if.sv
// uart_tx_if: valid/ready byte handshake between the upstream byte source
// and the UART transmit serializer.
interface uart_tx_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (
      output tx_data,
      output tx_valid,
      input  tx_ready
   );

   modport slave (
      input  tx_data,
      input  tx_valid,
      output tx_ready
   );
endinterface

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: turns held bytes into start/data/parity/stop frames,
// one bit per xmit_pulse, with a one-entry holding register for gapless frames.
module uart_tx_serializer (
   input  logic     clk,
   input  logic     reset_n,
   input  logic     xmit_pulse,
   input  logic     bit8,
   input  logic     parity_en,
   input  logic     odd_n_even,
   uart_tx_if.slave up,
   output logic     tx,
   output logic     tx_busy
);
   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_e;

   state_e     state_q, state_d;
   logic [7:0] hold_q, hold_d;
   logic [7:0] shift_q, shift_d;
   logic       hold_full_q, hold_full_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic       bit8_q, bit8_d;
   logic       par_en_q, par_en_d;
   logic       odd_q, odd_d;
   logic       tx_q, tx_d;
   logic       busy_q, busy_d;
   logic [2:0] last;
   logic       parity;

   assign up.tx_ready = !hold_full_q;
   assign tx          = tx_q;
   assign tx_busy     = busy_q;
   assign last        = bit8_q ? 3'd7 : 3'd6;
   // bit 7 only counts toward parity in 8-bit frames
   assign parity = odd_q ^ (^shift_q[6:0]) ^ (bit8_q & shift_q[7]);

   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      shift_d     = shift_q;
      hold_full_d = hold_full_q;
      bit_cnt_d   = bit_cnt_q;
      bit8_d      = bit8_q;
      par_en_d    = par_en_q;
      odd_d       = odd_q;
      tx_d        = tx_q;

      if (up.tx_valid && !hold_full_q) begin
         hold_d      = up.tx_data;
         hold_full_d = 1'b1;
      end

      if (xmit_pulse) begin
         unique case (state_q)
            IDLE, STOP: begin
               if (hold_full_q) begin
                  tx_d        = 1'b0;
                  shift_d     = hold_q;
                  bit8_d      = bit8;
                  par_en_d    = parity_en;
                  odd_d       = odd_n_even;
                  hold_full_d = 1'b0;
                  bit_cnt_d   = 3'd0;
                  state_d     = START;
               end else begin
                  tx_d    = 1'b1;
                  state_d = IDLE;
               end
            end
            START: begin
               tx_d    = shift_q[0];
               state_d = DATA;
            end
            DATA: begin
               if (bit_cnt_q == last) begin
                  if (par_en_q) begin
                     tx_d    = parity;
                     state_d = PARITY;
                  end else begin
                     tx_d    = 1'b1;
                     state_d = STOP;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  tx_d      = shift_q[bit_cnt_d];
               end
            end
            PARITY: begin
               tx_d    = 1'b1;
               state_d = STOP;
            end
            default: begin
               tx_d    = 1'b1;
               state_d = IDLE;
            end
         endcase
      end

      busy_d = (state_d != IDLE) || hold_full_d;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         hold_q      <= 8'h00;
         shift_q     <= 8'h00;
         hold_full_q <= 1'b0;
         bit_cnt_q   <= 3'd0;
         bit8_q      <= 1'b0;
         par_en_q    <= 1'b0;
         odd_q       <= 1'b0;
         tx_q        <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         shift_q     <= shift_d;
         hold_full_q <= hold_full_d;
         bit_cnt_q   <= bit_cnt_d;
         bit8_q      <= bit8_d;
         par_en_q    <= par_en_d;
         odd_q       <= odd_d;
         tx_q        <= tx_d;
         busy_q      <= busy_d;
      end
   end
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: directed frames for uart_tx_serializer; expected
// serial patterns are queued on issue and checked by an independent line monitor.
module tb_uart_tx_serializer;
   logic clk;
   logic reset_n;
   logic xmit_pulse;
   logic bit8;
   logic parity_en;
   logic odd_n_even;
   logic tx;
   logic tx_busy;

   uart_tx_if bus ();

   uart_tx_serializer dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .xmit_pulse (xmit_pulse),
      .bit8       (bit8),
      .parity_en  (parity_en),
      .odd_n_even (odd_n_even),
      .up         (bus),
      .tx         (tx),
      .tx_busy    (tx_busy)
   );

   typedef struct packed {
      logic [11:0] bits;
      logic [3:0]  n;
      logic        b2b;
   } frame_t;

   frame_t exp_q[$];
   int     checks = 0;
   int     errors = 0;
   bit     mon_en = 1'b1;
   int     frame_idx = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      xmit_pulse = 1'b0;
      forever begin
         repeat (15) @(negedge clk);
         xmit_pulse = 1'b1;
         @(negedge clk);
         xmit_pulse = 1'b0;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [11:0] act,
                      input logic [11:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   // line monitor: frames are bit-period aligned, 16 clk per bit
   initial begin
      frame_t      e;
      logic [11:0] got;
      logic        cur;
      logic        stable;
      bit          pending = 1'b0;
      forever begin
         if (!pending) @(negedge clk);
         pending = 1'b0;
         if (mon_en && tx === 1'b0) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_frame", 12'(exp_q.size()), 12'd1);
               for (int k = 0; k < 400 && tx !== 1'b1; k++) @(negedge clk);
            end else begin
               e = exp_q.pop_front();
               got = 12'h000;
               stable = 1'b1;
               for (int b = 0; b < int'(e.n); b++) begin
                  for (int c = 0; c < 16; c++) begin
                     if (!(b == 0 && c == 0)) @(negedge clk);
                     if (c == 0) begin
                        cur = tx;
                        got[int'(e.n) - 1 - b] = tx;
                     end else if (tx !== cur) begin
                        stable = 1'b0;
                     end
                  end
               end
               chk($sformatf("frame%0d_bits", frame_idx), got, e.bits);
               chk($sformatf("frame%0d_bit_len", frame_idx),
                   12'(stable), 12'd1);
               @(negedge clk);
               pending = 1'b1;
               chk($sformatf("frame%0d_after_stop", frame_idx),
                   12'(tx), e.b2b ? 12'd0 : 12'd1);
               frame_idx++;
            end
         end
      end
   end

   task automatic send(input logic [7:0] d, input logic [11:0] bits,
                       input logic [3:0] n, input logic b2b,
                       output bit waited);
      int   t;
      logic prev;
      frame_t f;
      f.bits = bits;
      f.n = n;
      f.b2b = b2b;
      exp_q.push_back(f);
      bus.tx_data = d;
      bus.tx_valid = 1'b1;
      t = 0;
      waited = 1'b0;
      prev = tx;
      while (bus.tx_ready !== 1'b1 && t < 400) begin
         prev = tx;
         @(negedge clk);
         t++;
         waited = 1'b1;
      end
      chk("accept_wait", 12'(t < 400), 12'd1);
      if (waited)
         chk("ready_at_xfer", {10'd0, prev, tx}, 12'b10);
      @(negedge clk);
      bus.tx_valid = 1'b0;
      chk("ready_drop", 12'(bus.tx_ready), 12'd0);
      chk("busy_rise", 12'(tx_busy), 12'd1);
   endtask

   task automatic wait_idle();
      int t = 0;
      while (tx_busy !== 1'b0 && t < 1000) begin
         @(negedge clk);
         t++;
      end
      chk("idle_wait", 12'(t < 1000), 12'd1);
      @(negedge clk);
      chk("idle_tx", 12'(tx), 12'd1);
      chk("idle_ready", 12'(bus.tx_ready), 12'd1);
   endtask

   task automatic wait_xfer();
      int t = 0;
      while (bus.tx_ready !== 1'b1 && t < 400) begin
         @(negedge clk);
         t++;
      end
      chk("xfer_wait", 12'(t < 400), 12'd1);
   endtask

   initial begin
      bit w;
      bit bad;
      int t;
      reset_n = 1'b0;
      bus.tx_valid = 1'b0;
      bus.tx_data = 8'h00;
      bit8 = 1'b1;
      parity_en = 1'b0;
      odd_n_even = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_tx", 12'(tx), 12'd1);
      chk("reset_ready", 12'(bus.tx_ready), 12'd1);
      chk("reset_busy", 12'(tx_busy), 12'd0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      // 8N1 0xA5
      send(8'hA5, 12'b0101001011, 4'd10, 1'b0, w);
      wait_idle();

      // 7E1 0x41 with tx_data bit 7 set
      bit8 = 1'b0;
      parity_en = 1'b1;
      odd_n_even = 1'b0;
      send(8'hC1, 12'b0100000101, 4'd10, 1'b0, w);
      wait_idle();

      // 8O1 0x41; pins scrambled mid-frame must not matter
      bit8 = 1'b1;
      odd_n_even = 1'b1;
      send(8'h41, 12'b01000001011, 4'd11, 1'b0, w);
      wait_xfer();
      bit8 = 1'b0;
      parity_en = 1'b0;
      odd_n_even = 1'b0;
      wait_idle();
      bit8 = 1'b1;
      parity_en = 1'b1;
      odd_n_even = 1'b1;
      send(8'h00, 12'b00000000011, 4'd11, 1'b0, w);
      wait_idle();
      odd_n_even = 1'b0;
      send(8'hFF, 12'b01111111101, 4'd11, 1'b0, w);
      wait_idle();

      // back-to-back 8N1 with backpressure on the third byte
      parity_en = 1'b0;
      send(8'h55, 12'b0101010101, 4'd10, 1'b1, w);
      send(8'hAA, 12'b0010101011, 4'd10, 1'b1, w);
      send(8'h0F, 12'b0111100001, 4'd10, 1'b0, w);
      chk("backpressure", 12'(w), 12'd1);
      wait_idle();
      repeat (20) @(negedge clk);
      chk("queue_empty", 12'(exp_q.size()), 12'd0);

      // reset during data bit 3 with a byte held
      mon_en = 1'b0;
      send(8'h0F, 12'b0111100001, 4'd10, 1'b0, w);
      t = 0;
      while (tx !== 1'b0 && t < 400) begin
         @(negedge clk);
         t++;
      end
      chk("rst_start_wait", 12'(t < 400), 12'd1);
      send(8'h33, 12'b0110011001, 4'd10, 1'b0, w);
      repeat (70) @(negedge clk);
      chk("pre_reset_busy", 12'(tx_busy), 12'd1);
      chk("pre_reset_ready", 12'(bus.tx_ready), 12'd0);
      reset_n = 1'b0;
      @(negedge clk);
      chk("rst_mid_tx", 12'(tx), 12'd1);
      chk("rst_mid_ready", 12'(bus.tx_ready), 12'd1);
      chk("rst_mid_busy", 12'(tx_busy), 12'd0);
      reset_n = 1'b1;
      bad = 1'b0;
      repeat (640) begin
         @(negedge clk);
         if (tx !== 1'b1 || tx_busy !== 1'b0) bad = 1'b1;
      end
      chk("no_resume", 12'(bad), 12'd0);
      exp_q.delete();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
